// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - synchronous LIFO stack with full/empty flags and registered pop output
module lifo_stack #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  CE,
  input  logic                  nRW,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  FULL,
  output logic                  EMPTY
);

  localparam int             SLOTS = 1 << DEPTH;
  localparam logic [DEPTH:0] CAP   = (DEPTH + 1)'(SLOTS);

  // Storage is deliberately left out of reset; only slots written since reset are ever popped.
  logic [DATA_WIDTH-1:0] mem_q [SLOTS];

  logic [DEPTH:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  push, pop;
  logic [DEPTH-1:0]      wr_ptr, rd_ptr;

  // Status decode and operation qualification; reset discards the operation on its edge.
  always_comb begin
    FULL   = (count_q == CAP);
    EMPTY  = (count_q == '0);
    push   = CE &  nRW & ~FULL  & ~nRST;
    pop    = CE & ~nRW & ~EMPTY & ~nRST;
    // When not full the low bits of count address the next free slot.
    wr_ptr = count_q[DEPTH-1:0];
    // Top of stack is count-1; the low bits wrap correctly even when count == SLOTS.
    rd_ptr = count_q[DEPTH-1:0] - DEPTH'(1);
  end

  // Next-state for the count and the output register.
  always_comb begin
    count_d    = count_q;
    data_out_d = data_out_q;
    if (push) begin
      count_d = count_q + 1'b1;
    end else if (pop) begin
      count_d    = count_q - 1'b1;
      data_out_d = mem_q[rd_ptr];
    end
  end

  // Count and output registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Memory write on an accepted push.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr] <= DATA_IN;
    end
  end

  assign DATA_OUT = data_out_q;

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - directed self-checking bench for lifo_stack
module tb_lifo_stack;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       nrw;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;

  int n_cmp;
  int n_err;

  lifo_stack #(.DATA_WIDTH(8), .DEPTH(3)) dut (
    .CLK      (clk),
    .nRST     (rst),
    .CE       (ce),
    .nRW      (nrw),
    .DATA_IN  (din),
    .DATA_OUT (dout),
    .FULL     (full),
    .EMPTY    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic c, input logic w, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    ce  = c;
    nrw = w;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic pop();
    step(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [7:0] fill [8];
    logic [7:0] popd [8];
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    ce  = 1'b0;
    nrw = 1'b0;
    din = 8'h00;

    // 1. reset state, single push/pop
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst_dout",  dout, 8'h00);
    chk("rst_empty", {7'b0, empty}, 8'h01);
    chk("rst_full",  {7'b0, full},  8'h00);
    push(8'h2A);
    chk("t1_push_empty", {7'b0, empty}, 8'h00);
    chk("t1_push_dout",  dout, 8'h00);
    pop();
    chk("t1_pop_dout",  dout, 8'h2A);
    chk("t1_pop_empty", {7'b0, empty}, 8'h01);

    // 2. three pushes, two pops
    push(8'h18);
    push(8'h16);
    push(8'h44);
    pop();
    chk("t2_pop0", dout, 8'h44);
    pop();
    chk("t2_pop1", dout, 8'h16);
    chk("t2_empty", {7'b0, empty}, 8'h00);
    pop();
    chk("t2_pop2", dout, 8'h18);
    chk("t2_drained", {7'b0, empty}, 8'h01);

    // 3. fill to capacity, overflow push ignored
    fill = '{8'h15, 8'h15, 8'h21, 8'hFE, 8'hAC, 8'hAB, 8'h66, 8'h11};
    for (int i = 0; i < 8; i++) begin
      push(fill[i]);
      if (i == 6) chk("t3_full_at7", {7'b0, full}, 8'h00);
    end
    chk("t3_full_at8", {7'b0, full}, 8'h01);
    chk("t3_empty_at8", {7'b0, empty}, 8'h00);
    push(8'h33);
    chk("t3_full_ovf", {7'b0, full}, 8'h01);

    // 4. drain from full, underflow pop ignored
    popd = '{8'h11, 8'h66, 8'hAB, 8'hAC, 8'hFE, 8'h21, 8'h15, 8'h15};
    for (int i = 0; i < 8; i++) begin
      pop();
      chk($sformatf("t4_pop%0d", i), dout, popd[i]);
      if (i == 0) chk("t4_notfull", {7'b0, full}, 8'h00);
    end
    chk("t4_empty", {7'b0, empty}, 8'h01);
    pop();
    chk("t4_under_dout",  dout, 8'h15);
    chk("t4_under_empty", {7'b0, empty}, 8'h01);

    // 5. CE=0 holds all state
    push(8'h99);
    push(8'h5A);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, i[0], 8'hC0 + 8'(i));
    end
    chk("t5_dout",  dout, 8'h15);
    chk("t5_empty", {7'b0, empty}, 8'h00);
    chk("t5_full",  {7'b0, full},  8'h00);
    pop();
    chk("t5_pop0", dout, 8'h5A);
    pop();
    chk("t5_pop1", dout, 8'h99);
    chk("t5_drained", {7'b0, empty}, 8'h01);

    // 6. reset mid-sequence discards pending pop
    push(8'h55);
    push(8'h77);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t6_rst_empty", {7'b0, empty}, 8'h01);
    chk("t6_rst_dout",  dout, 8'h00);
    pop();
    chk("t6_pop_dout",  dout, 8'h00);
    chk("t6_pop_empty", {7'b0, empty}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
